// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU.
//   mode_t       : instruction mode, instr[7:6]
//   alu_op_t     : ALU opcodes carried on alu_opcode (110/111 unused, ALU returns 0)
//   cond_t       : condition codes for COND instructions, instr[2:0]
//   PORT_IDX     : register index that names the external in/out port
//   NULL_IDX     : register index that reads as zero / discards writes
//   exec_state_t : execute-stage FSM states
package cpu_pkg;

    typedef enum logic [1:0] {
        MODE_IMM  = 2'b00,
        MODE_ALU  = 2'b01,
        MODE_COPY = 2'b10,
        MODE_COND = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ALU_AND  = 3'd0,
        ALU_OR   = 3'd1,
        ALU_NAND = 3'd2,
        ALU_NOR  = 3'd3,
        ALU_ADD  = 3'd4,
        ALU_SUB  = 3'd5
    } alu_op_t;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'd0,
        COND_EQ     = 3'd1,
        COND_LT     = 3'd2,
        COND_LE     = 3'd3,
        COND_ALWAYS = 3'd4,
        COND_NE     = 3'd5,
        COND_GE     = 3'd6,
        COND_GT     = 3'd7
    } cond_t;

    localparam logic [2:0] PORT_IDX = 3'd6;
    localparam logic [2:0] NULL_IDX = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_IN  = 2'd1,
        S_WAIT_OUT = 2'd2
    } exec_state_t;

endpackage

// File: rtl/exec_stage_if.sv
// Bundle of the execute stage's handshake and data signals.
//   instr / instr_valid / instr_ready       : instruction stream from fetch
//   alu_opcode / alu_a / alu_b / alu_result : ALU operands out, result back
//   in_data / in_valid / in_ready           : external input port
//   out_data / out_valid / out_ready        : external output port
//   jump_valid / jump_taken / jump_target   : condition evaluation result
// Modport slave is the execute stage; master is its surroundings.
interface exec_stage_if;

    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       jump_valid;
    logic       jump_taken;
    logic [7:0] jump_target;

    modport slave (
        input  instr, instr_valid, alu_result, in_data, in_valid, out_ready,
        output instr_ready, alu_opcode, alu_a, alu_b, in_ready,
               out_data, out_valid, jump_valid, jump_taken, jump_target
    );

    modport master (
        output instr, instr_valid, alu_result, in_data, in_valid, out_ready,
        input  instr_ready, alu_opcode, alu_a, alu_b, in_ready,
               out_data, out_valid, jump_valid, jump_taken, jump_target
    );

endinterface

// File: rtl/condition_unit.sv
// Combinational branch condition evaluator.
//   cond  : condition code
//   value : operand, interpreted as signed 8-bit
//   taken : 1 when the condition holds for value
module condition_unit
    import cpu_pkg::*;
(
    input  cond_t      cond,
    input  logic [7:0] value,
    output logic       taken
);

    logic neg;
    logic zero;

    always_comb begin
        neg   = value[7];
        zero  = (value == '0);
        taken = 1'b0;
        case (cond)
            COND_NEVER:  taken = 1'b0;
            COND_EQ:     taken = zero;
            COND_LT:     taken = neg;
            COND_LE:     taken = neg | zero;
            COND_ALWAYS: taken = 1'b1;
            COND_NE:     taken = ~zero;
            COND_GE:     taken = ~neg;
            COND_GT:     taken = ~neg & ~zero;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// Execute/writeback stage of the 8-bit CPU.
//   clock, reset : single clock, synchronous active-high reset
//   bus (slave)  : instruction handshake, ALU operands/result, in/out ports,
//                  jump result (see exec_stage_if)
// Holds r0..r5. IMM/ALU/COND and register-to-register COPY retire in the
// accept cycle; copies touching the port wait in WAIT_IN / WAIT_OUT.
module exec_stage
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_REGS = 6
) (
    input  logic         clock,
    input  logic         reset,
    exec_stage_if.slave  bus
);

    exec_state_t state_q, state_d;
    logic [7:0]  regs [NUM_REGS];
    logic [2:0]  dst_q, dst_d;
    logic [7:0]  out_data_q;
    logic        jump_valid_q, jump_taken_q;
    logic [7:0]  jump_target_q;

    mode_t       mode;
    logic [2:0]  src_idx, dst_idx;
    logic [7:0]  src_val;
    logic        accept;
    logic        cond_taken;

    // register-file single write port and output-port load, decided by the FSM
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [7:0]  wr_data;
    logic        out_load;
    logic [7:0]  out_load_data;
    logic        cond_fire;
    logic        instr_ready;

    assign mode    = mode_t'(bus.instr[7:6]);
    assign src_idx = bus.instr[5:3];
    assign dst_idx = bus.instr[2:0];
    assign accept  = bus.instr_valid & instr_ready;

    // NULL_IDX and PORT_IDX fall through to zero; the port source never uses src_val
    always_comb begin
        src_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (src_idx == i[2:0]) src_val = regs[i];
        end
    end

    condition_unit u_cond (
        .cond  (cond_t'(bus.instr[2:0])),
        .value (regs[3]),
        .taken (cond_taken)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        dst_d         = dst_q;
        wr_en         = 1'b0;
        wr_idx        = '0;
        wr_data       = '0;
        out_load      = 1'b0;
        out_load_data = '0;
        cond_fire     = 1'b0;
        instr_ready   = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                // gated by reset so the stage refuses work during the reset cycle
                instr_ready = ~reset;
                if (accept) begin
                    case (mode)
                        MODE_IMM: begin
                            wr_en   = 1'b1;
                            wr_idx  = 3'd0;
                            wr_data = {2'b00, bus.instr[5:0]};
                        end
                        MODE_ALU: begin
                            wr_en   = 1'b1;
                            wr_idx  = 3'd3;
                            wr_data = bus.alu_result;
                        end
                        MODE_COPY: begin
                            if (src_idx == PORT_IDX) begin
                                dst_d   = dst_idx;
                                state_d = S_WAIT_IN;
                            end else if (dst_idx == PORT_IDX) begin
                                out_load      = 1'b1;
                                out_load_data = src_val;
                                state_d       = S_WAIT_OUT;
                            end else if (dst_idx != NULL_IDX) begin
                                wr_en   = 1'b1;
                                wr_idx  = dst_idx;
                                wr_data = src_val;
                            end
                        end
                        MODE_COND: cond_fire = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_WAIT_IN: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (dst_q == PORT_IDX) begin
                        out_load      = 1'b1;
                        out_load_data = bus.in_data;
                        state_d       = S_WAIT_OUT;
                    end else begin
                        wr_en   = (dst_q != NULL_IDX);
                        wr_idx  = dst_q;
                        wr_data = bus.in_data;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            out_data_q    <= '0;
            jump_valid_q  <= 1'b0;
            jump_taken_q  <= 1'b0;
            jump_target_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_en && wr_idx == i[2:0]) regs[i] <= wr_data;
            end
            if (out_load) out_data_q <= out_load_data;
            jump_valid_q <= cond_fire;
            jump_taken_q <= cond_fire & cond_taken;
            if (cond_fire) jump_target_q <= regs[0];
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.alu_opcode  = bus.instr[2:0];
    assign bus.alu_a       = regs[1];
    assign bus.alu_b       = regs[2];
    assign bus.out_data    = out_data_q;
    assign bus.jump_valid  = jump_valid_q;
    assign bus.jump_taken  = jump_taken_q;
    assign bus.jump_target = jump_target_q;

endmodule
